// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode map,
// ALU function codes, flag bit positions and the opcode classifier.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_RR,
    CLS_ALU_RI,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_BR,
    CLS_HALT,
    CLS_ILL
  } op_class_t;

  localparam logic [4:0] OPC_ALU_RR = 5'b00000;
  localparam logic [4:0] OPC_ALU_RI = 5'b00001;
  localparam logic [4:0] OPC_LD     = 5'b00100;
  localparam logic [4:0] OPC_ST     = 5'b00101;
  localparam logic [4:0] OPC_JMP    = 5'b10000;
  localparam logic [4:0] OPC_HALT   = 5'b11111;
  localparam logic [1:0] OPC_BR_PFX = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_S = 3;

  function automatic op_class_t classify(input logic [4:0] opc);
    op_class_t cls;
    cls = CLS_ILL;
    if (opc[4:3] == OPC_BR_PFX) begin
      cls = CLS_BR;
    end else begin
      case (opc)
        OPC_ALU_RR: cls = CLS_ALU_RR;
        OPC_ALU_RI: cls = CLS_ALU_RI;
        OPC_LD:     cls = CLS_LD;
        OPC_ST:     cls = CLS_ST;
        OPC_JMP:    cls = CLS_JMP;
        OPC_HALT:   cls = CLS_HALT;
        default:    cls = CLS_ILL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction- and data-memory req/ack handshakes between controller and memories.
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic dmem_we;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input  imem_ack, input  dmem_ack);
  modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/multicycle_controller_branch_cond_eval.sv
// Branch condition: opcode 01ccn selects flag cc ({S,V,C,Z}); n inverts the sense.
module branch_cond_eval
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned NFLAGS = 4
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [NFLAGS-1:0] flags,
  output logic              taken
);

  logic flag_sel;
  logic unused_opc_hi;

  assign unused_opc_hi = ^opcode[OPC_W-1:3];

  always_comb begin
    flag_sel = 1'b0;
    case (opcode[2:1])
      2'b00:   flag_sel = flags[FLAG_Z];
      2'b01:   flag_sel = flags[FLAG_C];
      2'b10:   flag_sel = flags[FLAG_V];
      2'b11:   flag_sel = flags[FLAG_S];
      default: flag_sel = 1'b0;
    endcase
    taken = flag_sel ^ opcode[0];
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// wait-state handshakes, conditional branches, HALT and illegal-opcode trap.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned INS_W  = 16,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned FUNC_W = 3,
  parameter int unsigned NFLAGS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INS_W-1:0]       ins,
  input  logic [NFLAGS-1:0]      flags,
  multicycle_controller_if.master mem,
  output logic                   ir_ld,
  output logic                   pc_inc,
  output logic                   pc_ld,
  output logic                   rf_re1,
  output logic                   rf_re2,
  output logic                   rf_we,
  output logic                   alu_src_imm,
  output logic [FUNC_W-1:0]      alu_func,
  output logic                   flags_ld,
  output logic                   wb_sel,
  output logic                   halted,
  output logic                   illegal
);

  if (OPC_W != 5) begin : g_opc_w_check
    $error("multicycle_controller: fixed-field opcode decode requires OPC_W == 5");
  end

  state_t           state;
  op_class_t        cls;
  logic [OPC_W-1:0] opcode;
  logic             br_taken;
  logic             unused_ins_mid;

  assign opcode         = ins[INS_W-1 -: OPC_W];
  assign cls            = classify(opcode);
  assign unused_ins_mid = ^ins[INS_W-OPC_W-1:FUNC_W];

  branch_cond_eval #(
    .OPC_W  (OPC_W),
    .NFLAGS (NFLAGS)
  ) u_branch_cond_eval (
    .opcode (opcode),
    .flags  (flags),
    .taken  (br_taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (mem.imem_ack) state <= DECODE;
        DECODE: begin
          case (cls)
            CLS_HALT: state <= HALT;
            CLS_ILL:  state <= FETCH;
            default:  state <= EXEC;
          endcase
        end
        EXEC: begin
          case (cls)
            CLS_ALU_RR, CLS_ALU_RI: state <= WB;
            CLS_LD, CLS_ST:         state <= MEM;
            default:                state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem.dmem_ack) state <= (cls == CLS_LD) ? WB : FETCH;
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state plus the live IR/flags: DECODE and EXEC act on
  // the instruction and flags of the current cycle, so they cannot be pre-registered.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    rf_re1       = 1'b0;
    rf_re2       = 1'b0;
    rf_we        = 1'b0;
    alu_src_imm  = 1'b0;
    alu_func     = '0;
    flags_ld     = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      FETCH: begin
        mem.imem_req = 1'b1;
        ir_ld        = mem.imem_ack;
        pc_inc       = mem.imem_ack;
      end
      DECODE: begin
        rf_re1  = 1'b1;
        rf_re2  = (cls == CLS_ALU_RR) || (cls == CLS_ST);
        illegal = (cls == CLS_ILL);
      end
      EXEC: begin
        case (cls)
          CLS_ALU_RR: begin
            alu_func = ins[FUNC_W-1:0];
            flags_ld = 1'b1;
          end
          CLS_ALU_RI: begin
            alu_src_imm = 1'b1;
            alu_func    = FUNC_W'(ALU_ADD);
            flags_ld    = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            alu_src_imm = 1'b1;
            alu_func    = FUNC_W'(ALU_ADD);
          end
          CLS_JMP: pc_ld = 1'b1;
          CLS_BR:  pc_ld = br_taken;
          default: ;
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (cls == CLS_ST);
      end
      WB: begin
        rf_we  = 1'b1;
        wb_sel = (cls == CLS_LD);
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench: per-instruction strobe counts and latency
// compared with an instruction-level model derived from the opcode rules.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ins;
  logic [3:0]  flags;
  logic        ir_ld, pc_inc, pc_ld, rf_re1, rf_re2, rf_we, alu_src_imm;
  logic [2:0]  alu_func;
  logic        flags_ld, wb_sel, halted, illegal;
  logic [16:0] outs_v;

  multicycle_controller_if mem_if();

  multicycle_controller #(
    .INS_W  (16),
    .OPC_W  (5),
    .FUNC_W (3),
    .NFLAGS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .flags       (flags),
    .mem         (mem_if),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .rf_re1      (rf_re1),
    .rf_re2      (rf_re2),
    .rf_we       (rf_we),
    .alu_src_imm (alu_src_imm),
    .alu_func    (alu_func),
    .flags_ld    (flags_ld),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign outs_v = {ir_ld, pc_inc, pc_ld, rf_re1, rf_re2, rf_we, alu_src_imm, alu_func,
                   flags_ld, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we,
                   wb_sel, halted, illegal};

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct {
    int unsigned lat;
    int unsigned n_ireq, n_irld, n_pcinc, n_pcld, n_re1, n_re2;
    int unsigned n_we, n_fld, n_dreq, n_dwe, n_ill;
    logic        wbsel;
    logic [2:0]  func;
    logic        srcimm;
    logic        hlt;
  } stats_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Instruction-level expectations: whole-instruction latency and strobe counts.
  function automatic stats_t model(input logic [15:0] i, input logic [3:0] f,
                                   input int unsigned iw, input int unsigned dw);
    stats_t e;
    logic [4:0] opc;
    bit alu, ld, st, jmp, br, hlt, ill, taken;
    opc   = i[15:11];
    alu   = (opc == 5'b00000) || (opc == 5'b00001);
    ld    = (opc == 5'b00100);
    st    = (opc == 5'b00101);
    jmp   = (opc == 5'b10000);
    br    = (opc[4:3] == 2'b01);
    hlt   = (opc == 5'b11111);
    ill   = !(alu || ld || st || jmp || br || hlt);
    taken = f[opc[2:1]] ^ opc[0];
    e = '{default: 0};
    e.lat     = iw + (alu ? 4 : ld ? 5 + dw : st ? 4 + dw : (jmp || br) ? 3 : 2);
    e.n_ireq  = iw + 1;
    e.n_irld  = 1;
    e.n_pcinc = 1;
    e.n_re1   = 1;
    e.n_re2   = (opc == 5'b00000 || st) ? 1 : 0;
    e.n_we    = (alu || ld) ? 1 : 0;
    e.n_fld   = alu ? 1 : 0;
    e.n_dreq  = (ld || st) ? dw + 1 : 0;
    e.n_dwe   = st ? dw + 1 : 0;
    e.n_ill   = ill ? 1 : 0;
    e.n_pcld  = jmp ? 1 : (br && taken) ? 1 : 0;
    e.wbsel   = ld;
    e.func    = (opc == 5'b00000) ? i[2:0] : 3'b000;
    e.srcimm  = (opc == 5'b00001);
    e.hlt     = hlt;
    return e;
  endfunction

  // Entered at negedge+1 of a FETCH cycle with acks low; returns likewise
  // in the next FETCH cycle (or in the first HALT cycle).
  task automatic run_instr(input logic [15:0] i, input logic [3:0] f,
                           input int unsigned iw, input int unsigned dw);
    stats_t o, e;
    int unsigned icnt, dcnt;
    bit got_ir, done;
    o = '{default: 0};
    e = model(i, f, iw, dw);
    icnt = 0; dcnt = 0; got_ir = 0; done = 0;
    ins   = 16'($urandom);
    flags = f;
    for (int c = 0; c < 64 && !done; c++) begin
      if (got_ir && (mem_if.imem_req || halted)) begin
        o.lat = c;
        o.hlt = halted;
        done  = 1;
      end else begin
        mem_if.imem_ack = mem_if.imem_req && (icnt >= iw);
        mem_if.dmem_ack = mem_if.dmem_req && (dcnt >= dw);
        if (mem_if.imem_req) icnt++;
        if (mem_if.dmem_req) dcnt++;
        #1;
        if (mem_if.imem_req) o.n_ireq++;
        if (ir_ld)           o.n_irld++;
        if (pc_inc)          o.n_pcinc++;
        if (pc_ld)           o.n_pcld++;
        if (rf_re1)          o.n_re1++;
        if (rf_re2)          o.n_re2++;
        if (mem_if.dmem_req) o.n_dreq++;
        if (mem_if.dmem_we)  o.n_dwe++;
        if (illegal)         o.n_ill++;
        if (rf_we) begin
          o.n_we++;
          o.wbsel = wb_sel;
        end
        if (flags_ld) begin
          o.n_fld++;
          o.func   = alu_func;
          o.srcimm = alu_src_imm;
        end
        if (ir_ld) got_ir = 1;
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        if (got_ir) ins = i;
        #1;
      end
    end
    check($sformatf("done[%h]", i), 32'(done), 32'd1);
    check($sformatf("lat[%h]", i), o.lat, e.lat);
    check($sformatf("imem_req_cyc[%h]", i), o.n_ireq, e.n_ireq);
    check($sformatf("ir_ld[%h]", i), o.n_irld, e.n_irld);
    check($sformatf("pc_inc[%h]", i), o.n_pcinc, e.n_pcinc);
    check($sformatf("pc_ld[%h] f=%h", i, f), o.n_pcld, e.n_pcld);
    check($sformatf("rf_re1[%h]", i), o.n_re1, e.n_re1);
    check($sformatf("rf_re2[%h]", i), o.n_re2, e.n_re2);
    check($sformatf("rf_we[%h]", i), o.n_we, e.n_we);
    check($sformatf("wb_sel[%h]", i), 32'(o.wbsel), 32'(e.wbsel));
    check($sformatf("flags_ld[%h]", i), o.n_fld, e.n_fld);
    check($sformatf("alu_func[%h]", i), 32'(o.func), 32'(e.func));
    check($sformatf("alu_src_imm[%h]", i), 32'(o.srcimm), 32'(e.srcimm));
    check($sformatf("dmem_req_cyc[%h]", i), o.n_dreq, e.n_dreq);
    check($sformatf("dmem_we_cyc[%h]", i), o.n_dwe, e.n_dwe);
    check($sformatf("illegal[%h]", i), o.n_ill, e.n_ill);
    check($sformatf("halted[%h]", i), 32'(o.hlt), 32'(e.hlt));
  endtask

  task automatic reset_and_restart();
    rst = 1'b0;
    #1;
    check("reset_outs", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("idle_outs", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    check("fetch_restart", 32'(mem_if.imem_req), 32'd1);
  endtask

  initial begin
    logic [4:0]  opc;
    logic [3:0]  f;
    rst             = 1'b0;
    ins             = '0;
    flags           = '0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;

    #12;
    check("reset_outs", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("idle_outs", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    check("first_fetch", 32'(mem_if.imem_req), 32'd1);

    run_instr(16'b0000000000110101, 4'h0, 0, 0);

    // Every flag select, both senses, flag set and clear.
    for (int cc = 0; cc < 4; cc++) begin
      for (int n = 0; n < 2; n++) begin
        for (int fv = 0; fv < 2; fv++) begin
          opc    = {2'b01, 2'(cc), 1'(n)};
          f      = 4'($urandom);
          f[cc]  = 1'(fv);
          run_instr({opc, 11'b00000110101}, f, $urandom_range(1), 0);
        end
      end
    end

    run_instr(16'b0010000000110101, 4'h0, 0, 3);
    run_instr(16'b0010100000110101, 4'h0, 2, 0);
    run_instr(16'b0001110000110101, 4'h0, 0, 0);
    run_instr(16'b1000000000000101, 4'h0, 0, 0);
    run_instr(16'b0000100000000111, 4'h0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      opc = 5'($urandom);
      if (opc == 5'b11111) opc = 5'b00100;
      run_instr({opc, 11'($urandom)}, 4'($urandom), $urandom_range(3), $urandom_range(3));
    end

    run_instr(16'b1111100000000000, 4'($urandom), 1, 0);
    repeat (10) begin
      mem_if.imem_ack = 1'($urandom);
      mem_if.dmem_ack = 1'($urandom);
      @(negedge clk);
      #1;
      check("halt_sticky", 32'(outs_v), 32'h2);
    end
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    reset_and_restart();
    run_instr(16'b0000000000000011, 4'h5, 0, 0);

    // Reset while a data request is open: it must drop without a clock edge.
    mem_if.imem_ack = 1'b1;
    #1;
    @(negedge clk);
    mem_if.imem_ack = 1'b0;
    ins = 16'b0010000000000011;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mem_req_open", 32'(mem_if.dmem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_dmem_req_drop", 32'(mem_if.dmem_req), 32'd0);
    check("async_reset_outs", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("idle_after_mem_reset", 32'(outs_v), 32'd0);
    @(negedge clk);
    #1;
    check("fetch_after_mem_reset", 32'(mem_if.imem_req), 32'd1);
    run_instr(16'b0010000000000001, 4'h0, 1, 2);
    run_instr(16'b0000000000000110, 4'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
